// File: rtl/leg_mem_arbiter.sv
// Two-port valid/ready arbiter in front of the LEG core's single-port synchronous memory.
// One transaction in flight at a time; round-robin or fixed host priority on ties.
module leg_mem_arbiter #(
  parameter int ADDR_W    = 4,
  parameter int DATA_W    = 8,
  parameter int HOST_PRIO = 0
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic [1:0]        i_req_valid,
  output logic [1:0]        o_req_ready,
  input  logic [1:0]        i_req_we,
  input  logic [ADDR_W-1:0] i_req_addr0,
  input  logic [ADDR_W-1:0] i_req_addr1,
  input  logic [DATA_W-1:0] i_req_wdata0,
  input  logic [DATA_W-1:0] i_req_wdata1,
  output logic [1:0]        o_resp_valid,
  output logic [DATA_W-1:0] o_resp_rdata,
  output logic              o_mem_en,
  output logic              o_mem_we,
  output logic [ADDR_W-1:0] o_mem_addr,
  output logic [DATA_W-1:0] o_mem_wdata,
  input  logic [DATA_W-1:0] i_mem_rdata,
  output logic              o_busy
);

  // state    | meaning
  // S_IDLE   | ready offered to the arbitration winner, waiting for a handshake
  // S_ACCESS | memory strobed with the latched command
  // S_RESP   | completion pulse to the issuing port, read data forwarded from memory
  typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

  state_t              r_state;
  logic                r_last;
  logic                r_id;
  logic                r_we;
  logic [1:0]          r_resp_valid;
  logic                r_mem_en;
  logic                r_mem_we;
  logic [ADDR_W-1:0]   r_mem_addr;
  logic [DATA_W-1:0]   r_mem_wdata;

  logic [1:0]          w_grant;
  logic                w_gid;
  logic                w_hs;

  always_comb begin
    w_grant = 2'b00;
    if (r_state == S_IDLE) begin
      case (i_req_valid)
        2'b01:   w_grant = 2'b01;
        2'b10:   w_grant = 2'b10;
        2'b11: begin
          if (HOST_PRIO != 0) w_grant = 2'b10;
          else                w_grant = r_last ? 2'b01 : 2'b10;
        end
        default: w_grant = 2'b00;
      endcase
    end
  end

  assign w_gid = w_grant[1];
  assign w_hs  = |w_grant;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_state      <= S_IDLE;
      r_last       <= 1'b1;
      r_id         <= 1'b0;
      r_we         <= 1'b0;
      r_resp_valid <= 2'b00;
      r_mem_en     <= 1'b0;
      r_mem_we     <= 1'b0;
      r_mem_addr   <= '0;
      r_mem_wdata  <= '0;
    end else begin
      case (r_state)
        S_IDLE: begin
          if (w_hs) begin
            r_id        <= w_gid;
            r_last      <= w_gid;
            r_we        <= i_req_we[w_gid];
            r_mem_en    <= 1'b1;
            r_mem_we    <= i_req_we[w_gid];
            r_mem_addr  <= w_gid ? i_req_addr1  : i_req_addr0;
            r_mem_wdata <= w_gid ? i_req_wdata1 : i_req_wdata0;
            r_state     <= S_ACCESS;
          end
        end
        S_ACCESS: begin
          // memory outputs return to zero as soon as the strobe drops
          r_mem_en     <= 1'b0;
          r_mem_we     <= 1'b0;
          r_mem_addr   <= '0;
          r_mem_wdata  <= '0;
          r_resp_valid <= r_id ? 2'b10 : 2'b01;
          r_state      <= S_RESP;
        end
        S_RESP: begin
          r_resp_valid <= 2'b00;
          r_state      <= S_IDLE;
        end
        default: r_state <= S_IDLE;
      endcase
    end
  end

  assign o_req_ready  = w_grant;
  assign o_resp_valid = r_resp_valid;
  // read data arrives from memory one cycle after the strobe, i.e. during S_RESP
  assign o_resp_rdata = (r_state == S_RESP && !r_we) ? i_mem_rdata : '0;
  assign o_mem_en     = r_mem_en;
  assign o_mem_we     = r_mem_we;
  assign o_mem_addr   = r_mem_addr;
  assign o_mem_wdata  = r_mem_wdata;
  assign o_busy       = (r_state != S_IDLE);

endmodule

// File: tb/tb_leg_mem_arbiter.sv
// Directed bench: a round-robin instance (a_*) and a host-priority instance (b_*),
// each in front of its own 16x8 synchronous memory model.
module tb_leg_mem_arbiter;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  int         total = 0;
  int         bad = 0;

  always #5 clk = ~clk;

  logic [1:0] a_valid = 2'b00, a_we = 2'b00, a_ready, a_resp_valid;
  logic [3:0] a_addr0 = '0, a_addr1 = '0, a_mem_addr;
  logic [7:0] a_wd0 = '0, a_wd1 = '0, a_resp_rdata, a_mem_wdata, a_mem_rdata;
  logic       a_mem_en, a_mem_we, a_busy;
  logic [7:0] mem0 [16] = '{3: 8'h57, 4: 8'hA4, 5: 8'hB5, default: 8'h00};

  logic [1:0] b_valid = 2'b00, b_we = 2'b00, b_ready, b_resp_valid;
  logic [3:0] b_addr0 = '0, b_addr1 = '0, b_mem_addr;
  logic [7:0] b_wd0 = '0, b_wd1 = '0, b_resp_rdata, b_mem_wdata, b_mem_rdata;
  logic       b_mem_en, b_mem_we, b_busy;
  logic [7:0] mem1 [16] = '{3: 8'h57, 4: 8'hA4, 5: 8'hB5, default: 8'h00};

  leg_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .HOST_PRIO(0)) dut_a (
    .i_clk(clk), .i_rst(rst), .i_req_valid(a_valid), .o_req_ready(a_ready),
    .i_req_we(a_we), .i_req_addr0(a_addr0), .i_req_addr1(a_addr1),
    .i_req_wdata0(a_wd0), .i_req_wdata1(a_wd1), .o_resp_valid(a_resp_valid),
    .o_resp_rdata(a_resp_rdata), .o_mem_en(a_mem_en), .o_mem_we(a_mem_we),
    .o_mem_addr(a_mem_addr), .o_mem_wdata(a_mem_wdata), .i_mem_rdata(a_mem_rdata),
    .o_busy(a_busy));

  leg_mem_arbiter #(.ADDR_W(4), .DATA_W(8), .HOST_PRIO(1)) dut_b (
    .i_clk(clk), .i_rst(rst), .i_req_valid(b_valid), .o_req_ready(b_ready),
    .i_req_we(b_we), .i_req_addr0(b_addr0), .i_req_addr1(b_addr1),
    .i_req_wdata0(b_wd0), .i_req_wdata1(b_wd1), .o_resp_valid(b_resp_valid),
    .o_resp_rdata(b_resp_rdata), .o_mem_en(b_mem_en), .o_mem_we(b_mem_we),
    .o_mem_addr(b_mem_addr), .o_mem_wdata(b_mem_wdata), .i_mem_rdata(b_mem_rdata),
    .o_busy(b_busy));

  always @(posedge clk) begin
    if (a_mem_en) begin
      if (a_mem_we) mem0[a_mem_addr] <= a_mem_wdata;
      a_mem_rdata <= mem0[a_mem_addr];
    end
    if (b_mem_en) begin
      if (b_mem_we) mem1[b_mem_addr] <= b_mem_wdata;
      b_mem_rdata <= mem1[b_mem_addr];
    end
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp)
    else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Single-port transaction on the round-robin instance, checked cycle by cycle.
  task automatic txn_a(input int port, input logic we, input logic [3:0] addr,
                       input logic [7:0] wdata, input logic [7:0] exp_rdata);
    logic [1:0] oh;
    oh = (port == 1) ? 2'b10 : 2'b01;
    @(negedge clk);
    a_valid = oh;
    a_we    = we ? oh : 2'b00;
    if (port == 1) begin a_addr1 = addr; a_wd1 = wdata; end
    else           begin a_addr0 = addr; a_wd0 = wdata; end
    #1 chk("txn_ready", 32'(a_ready), 32'(oh));
    @(negedge clk);
    a_valid = 2'b00;
    #1;
    chk("txn_mem_en",   32'(a_mem_en),   32'h1);
    chk("txn_mem_we",   32'(a_mem_we),   32'(we));
    chk("txn_mem_addr", 32'(a_mem_addr), 32'(addr));
    if (we) chk("txn_mem_wdata", 32'(a_mem_wdata), 32'(wdata));
    chk("txn_busy",     32'(a_busy),     32'h1);
    chk("txn_ready_busy", 32'(a_ready),  32'h0);
    @(negedge clk);
    #1;
    chk("txn_resp_valid", 32'(a_resp_valid), 32'(oh));
    chk("txn_resp_rdata", 32'(a_resp_rdata), 32'(exp_rdata));
    chk("txn_mem_en_off", 32'(a_mem_en),     32'h0);
  endtask

  initial begin
    // reset state
    rst = 1'b1;
    repeat (2) @(negedge clk);
    #1;
    chk("rst_ready",      32'(a_ready),      32'h0);
    chk("rst_resp_valid", 32'(a_resp_valid), 32'h0);
    chk("rst_resp_rdata", 32'(a_resp_rdata), 32'h0);
    chk("rst_mem_en",     32'(a_mem_en),     32'h0);
    chk("rst_mem_we",     32'(a_mem_we),     32'h0);
    chk("rst_mem_addr",   32'(a_mem_addr),   32'h0);
    chk("rst_mem_wdata",  32'(a_mem_wdata),  32'h0);
    chk("rst_busy",       32'(a_busy),       32'h0);
    rst = 1'b0;

    // 1: port 0 reads addr 3
    txn_a(0, 1'b0, 4'd3, 8'h00, 8'h57);
    @(negedge clk); #1;
    chk("t1_idle_resp",  32'(a_resp_valid), 32'h0);
    chk("t1_idle_rdata", 32'(a_resp_rdata), 32'h0);
    chk("t1_idle_busy",  32'(a_busy),       32'h0);

    // 2: port 1 writes 0x21 to addr 2, then reads it back
    txn_a(1, 1'b1, 4'd2, 8'h21, 8'h00);
    chk("t2_mem_written", 32'(mem0[2]), 32'h21);
    txn_a(1, 1'b0, 4'd2, 8'h00, 8'h21);

    // 3: continuous contention after reset, round-robin
    @(negedge clk);
    rst = 1'b1;
    @(negedge clk);
    rst = 1'b0;
    a_valid = 2'b11; a_we = 2'b00; a_addr0 = 4'd4; a_addr1 = 4'd5;
    for (int i = 0; i < 4; i++) begin
      logic [1:0] exp_oh;
      exp_oh = (i % 2 == 1) ? 2'b10 : 2'b01;
      #1 chk("t3_grant", 32'(a_ready), 32'(exp_oh));
      @(negedge clk); #1;
      chk("t3_addr",       32'(a_mem_addr), (i % 2 == 1) ? 32'h5 : 32'h4);
      chk("t3_ready_busy", 32'(a_ready),    32'h0);
      @(negedge clk); #1;
      chk("t3_resp_valid", 32'(a_resp_valid), 32'(exp_oh));
      chk("t3_resp_rdata", 32'(a_resp_rdata), (i % 2 == 1) ? 32'hB5 : 32'hA4);
      @(negedge clk);
    end
    a_valid = 2'b00;

    // 4: contention with host priority
    b_valid = 2'b11; b_we = 2'b00; b_addr0 = 4'd4; b_addr1 = 4'd5;
    for (int i = 0; i < 2; i++) begin
      #1 chk("t4_grant", 32'(b_ready), 32'h2);
      @(negedge clk); #1;
      chk("t4_addr", 32'(b_mem_addr), 32'h5);
      @(negedge clk); #1;
      chk("t4_resp_valid", 32'(b_resp_valid), 32'h2);
      chk("t4_resp_rdata", 32'(b_resp_rdata), 32'hB5);
      @(negedge clk);
    end
    b_valid = 2'b01;
    #1 chk("t4_port0_grant", 32'(b_ready), 32'h1);
    @(negedge clk); #1;
    b_valid = 2'b00;
    chk("t4_port0_addr", 32'(b_mem_addr), 32'h4);
    @(negedge clk); #1;
    chk("t4_port0_resp",  32'(b_resp_valid), 32'h1);
    chk("t4_port0_rdata", 32'(b_resp_rdata), 32'hA4);

    // 5: reset during S_ACCESS of a port 0 read (port 0 becomes r_last first)
    @(negedge clk);
    a_valid = 2'b01; a_we = 2'b00; a_addr0 = 4'd3;
    #1 chk("t5_grant", 32'(a_ready), 32'h1);
    @(negedge clk);
    a_valid = 2'b00;
    #1 chk("t5_access", 32'(a_mem_en), 32'h1);
    rst = 1'b1;
    @(negedge clk); #1;
    chk("t5_resp_valid", 32'(a_resp_valid), 32'h0);
    chk("t5_mem_en",     32'(a_mem_en),     32'h0);
    chk("t5_mem_addr",   32'(a_mem_addr),   32'h0);
    chk("t5_busy",       32'(a_busy),       32'h0);
    chk("t5_rdata",      32'(a_resp_rdata), 32'h0);
    rst = 1'b0;
    @(negedge clk); #1;
    chk("t5_no_late_resp", 32'(a_resp_valid), 32'h0);
    a_valid = 2'b11; a_addr0 = 4'd4; a_addr1 = 4'd5;
    #1 chk("t5_tie_port0", 32'(a_ready), 32'h1);
    @(negedge clk);
    a_valid = 2'b00;
    @(negedge clk); #1;
    chk("t5_tie_resp",  32'(a_resp_valid), 32'h1);
    chk("t5_tie_rdata", 32'(a_resp_rdata), 32'hA4);

    // 6: port 0 raises valid while busy and withdraws it before S_IDLE
    @(negedge clk);
    a_valid = 2'b10; a_addr1 = 4'd5;
    #1 chk("t6_grant1", 32'(a_ready), 32'h2);
    @(negedge clk);
    a_valid = 2'b01; a_addr0 = 4'd3;
    #1 chk("t6_ready_busy", 32'(a_ready), 32'h0);
    @(negedge clk);
    a_valid = 2'b00;
    #1;
    chk("t6_resp1",       32'(a_resp_valid), 32'h2);
    chk("t6_ready_resp",  32'(a_ready),      32'h0);
    @(negedge clk); #1;
    chk("t6_no_access",   32'(a_mem_en),     32'h0);
    chk("t6_idle",        32'(a_busy),       32'h0);
    @(negedge clk); #1;
    chk("t6_still_idle",  32'(a_mem_en),     32'h0);
    chk("t6_no_resp",     32'(a_resp_valid), 32'h0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
